asynchronous_fifo_write_controller: RTL
=======================================

Name: asynchronous_fifo_write_controller

Overview:
Write-domain half of the asynchronous FIFO. It accepts words from the producer and drives the dual-port memory write port. It publishes a flop-sourced Gray write pointer to the read controller. It brings the read controller's Gray read pointer into this domain and generates full, almost_full, fill_level and a sticky overflow flag.

Parameters:
DATA_WIDTH, 16, width of each stored word.
DATA_DEPTH, 4096, memory entries; power of two, at least 4. Usable capacity is DATA_DEPTH-1.
ALMOST_FULL_THRESHOLD, 4088, fill_level at or above which almost_full asserts; range 1..DATA_DEPTH-1.

Ports:
clock  input  1  write-domain clock.
reset  input  1  synchronous, active-high reset.
write_enable  input  1  producer requests a write this cycle.
write_data  input  DATA_WIDTH  word to store.
read_pointer_gray  input  $clog2(DATA_DEPTH)  Gray read pointer from the read controller (read clock domain).
memory_write_enable  output  1  memory write strobe.
memory_write_address  output  $clog2(DATA_DEPTH)  memory write address.
memory_write_data  output  DATA_WIDTH  memory write data.
write_pointer_gray  output  $clog2(DATA_DEPTH)  registered Gray write pointer, to the read domain.
write_strobe  output  1  registered copy of an accepted write, to the read controller's write_enable input.
full  output  1  no free slot; writes this cycle are dropped.
almost_full  output  1  fill_level >= ALMOST_FULL_THRESHOLD.
fill_level  output  $clog2(DATA_DEPTH)  conservative occupancy count.
overflow  output  1  sticky; set when a write is attempted while full.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Reset values: write_pointer=0, write_pointer_gray=0, both synchronizer stages=0, write_strobe=0, overflow=0. Consequently full=0, almost_full=0, fill_level=0, memory_write_enable=0.
- Synchronizer:
  - read_pointer_gray passes through two flops, sync_stage_1 then sync_stage_2.
  - read_pointer_sync is the Gray-to-binary decode of sync_stage_2: bit i = XOR of (sync_stage_2 >> i).
  - Latency: 2 edges from an input change until the change is visible in read_pointer_sync.
- Status decodes, all combinational from registers only:
  - full = ((write_pointer + 1) mod DATA_DEPTH == read_pointer_sync).
  - fill_level = (write_pointer - read_pointer_sync) mod DATA_DEPTH, using $clog2(DATA_DEPTH)-bit wrap arithmetic.
  - almost_full = (fill_level >= ALMOST_FULL_THRESHOLD).
- One slot is always sacrificed, so write_pointer == read_pointer always means empty. This matches the read controller's empty rule.
- Accepted write, when write_enable && !full:
  - Same cycle: memory_write_enable=1, memory_write_address=write_pointer, memory_write_data=write_data.
  - Next edge: write_pointer advances to write_pointer+1, wrapping DATA_DEPTH-1 to 0.
  - Next edge: write_pointer_gray is loaded with gray(next pointer) = next ^ (next >> 1), so it is flop-sourced and updates on the same edge as the pointer.
  - Next edge: write_strobe is registered to 1.
- Rejected write, when write_enable && full:
  - memory_write_enable=0; the pointer holds.
  - overflow is set and stays set until reset.
- Idle (write_enable=0): memory_write_enable=0, memory_write_address=write_pointer, write_strobe registers 0.
- Simultaneous events: full is evaluated from the current registered state. If a read frees a slot in the same cycle a write is attempted while full, the write is still rejected.
- Pessimism: full and fill_level lag actual reads by 2–3 write clocks. They never under-report occupancy.
- Reset mid-operation: all state returns to reset values on the next edge, and any in-flight write that cycle is dropped. The system must reset the read controller in the same window; this block does not detect a one-sided reset.

Decomposition:
- Package asynchronous_fifo_package: binary_to_gray and gray_to_binary functions, parameterised by width.
- Sub-module asynchronous_fifo_pointer_synchronizer: 2-flop, width-parameterised, synchronous active-high reset. Reusable by the read side.

Test Plan:
(All scenarios use DATA_DEPTH=8, ALMOST_FULL_THRESHOLD=6, read_pointer_gray held at 0 unless stated.)
1. Reset asserted for 3 cycles, then released -> every output is 0; full=0; fill_level=0.
2. 7 back-to-back writes of 0xA0..0xA6 -> memory_write_address 0..6; write_pointer_gray sequence 1,3,2,6,7,5,4; almost_full=1 once fill_level=6; full=1 after the 7th write.
3. Continuing from 2, write 0xA7 while full -> memory_write_enable=0, pointer holds at 7, overflow=1 and stays 1.
4. Continuing from 3, read_pointer_gray set to 3 (binary 2) -> fill_level and full unchanged for 1 edge; after the 2nd edge fill_level=5, full=0, almost_full=0; the next write is accepted at address 7.
5. Continuing from 4, write at address 7 -> pointer wraps to 0; write_pointer_gray changes 4 then 0; the next write goes to address 0.
6. Reset asserted mid-burst while write_enable=1 -> the write in the reset cycle is dropped; pointer=0, write_pointer_gray=0, overflow=0 on the following cycle.

Source files
------------

// File: rtl/asynchronous_fifo_write_controller_pkg.sv
// rtl/asynchronous_fifo_write_controller_pkg.sv - Gray-code helpers shared by both FIFO clock domains
//
// Purpose:
//   Pointer encode/decode functions for the asynchronous FIFO.
//   Both functions work on a wide pointer word. Callers zero-extend their
//   pointer into pointer_word_t and narrow the result back with a width cast.
//   Leading zeros do not disturb either conversion, so this is exact for any
//   pointer width up to MAX_POINTER_WIDTH.
//
// Contents:
//   MAX_POINTER_WIDTH  widest pointer the helpers support
//   pointer_word_t     wide pointer carrier type
//   binary_to_gray     value ^ (value >> 1)
//   gray_to_binary     bit i = XOR of (value >> i)

package asynchronous_fifo_package;

  localparam int MAX_POINTER_WIDTH = 32;

  typedef logic [MAX_POINTER_WIDTH-1:0] pointer_word_t;

  function automatic pointer_word_t binary_to_gray(input pointer_word_t value);
    return value ^ (value >> 1);
  endfunction

  function automatic pointer_word_t gray_to_binary(input pointer_word_t value);
    pointer_word_t result;
    result = '0;
    for (int i = 0; i < MAX_POINTER_WIDTH; i++) begin
      result = result ^ (value >> i);
    end
    return result;
  endfunction

endpackage

// File: rtl/asynchronous_fifo_pointer_synchronizer.sv
// rtl/asynchronous_fifo_pointer_synchronizer.sv - two-flop synchronizer for a Gray-coded pointer
//
// Purpose:
//   Brings a Gray pointer from the far clock domain into the local one.
//   Because only one bit of a Gray pointer changes per step, a stage that
//   samples mid-transition resolves to either the old or the new pointer,
//   never to an unrelated value. Reusable by the read-side controller.
//
// Ports:
//   i_clock  local clock
//   i_reset  synchronous, active-high reset (clears both stages)
//   i_data   Gray pointer from the other clock domain
//   o_data   synchronized Gray pointer (second stage)

module asynchronous_fifo_pointer_synchronizer #(
  parameter int WIDTH = 12
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_sync_stage_1;
  logic [WIDTH-1:0] r_sync_stage_2;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync_stage_1 <= '0;
      r_sync_stage_2 <= '0;
    end else begin
      r_sync_stage_1 <= i_data;
      r_sync_stage_2 <= r_sync_stage_1;
    end
  end

  assign o_data = r_sync_stage_2;

endmodule

// File: rtl/asynchronous_fifo_write_controller.sv
// rtl/asynchronous_fifo_write_controller.sv - write-domain half of the asynchronous FIFO
//
// Purpose:
//   Accepts producer words and drives the memory write port. Publishes a
//   flop-sourced Gray write pointer to the read domain and synchronizes the
//   read domain's Gray pointer back. Derives full, almost_full, fill_level
//   and a sticky overflow flag from registered state only.
//   One slot is always left unused, so equal pointers always mean empty.
//
// Ports:
//   clock                 write-domain clock
//   reset                 synchronous, active-high reset
//   write_enable          producer requests a write this cycle
//   write_data            word to store
//   read_pointer_gray     Gray read pointer from the read domain
//   memory_write_enable   memory write strobe (accepted write this cycle)
//   memory_write_address  memory write address (current write pointer)
//   memory_write_data     memory write data
//   write_pointer_gray    registered Gray write pointer, to the read domain
//   write_strobe          registered copy of an accepted write
//   full                  no free slot; writes this cycle are dropped
//   almost_full           fill_level >= ALMOST_FULL_THRESHOLD
//   fill_level            conservative occupancy count
//   overflow              sticky; a write was attempted while full

module asynchronous_fifo_write_controller
  import asynchronous_fifo_package::*;
#(
  parameter int DATA_WIDTH            = 16,
  parameter int DATA_DEPTH            = 4096,
  parameter int ALMOST_FULL_THRESHOLD = 4088
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          write_enable,
  input  logic [DATA_WIDTH-1:0]         write_data,
  input  logic [$clog2(DATA_DEPTH)-1:0] read_pointer_gray,
  output logic                          memory_write_enable,
  output logic [$clog2(DATA_DEPTH)-1:0] memory_write_address,
  output logic [DATA_WIDTH-1:0]         memory_write_data,
  output logic [$clog2(DATA_DEPTH)-1:0] write_pointer_gray,
  output logic                          write_strobe,
  output logic                          full,
  output logic                          almost_full,
  output logic [$clog2(DATA_DEPTH)-1:0] fill_level,
  output logic                          overflow
);

  localparam int POINTER_WIDTH = $clog2(DATA_DEPTH);

  // State
  logic [POINTER_WIDTH-1:0] r_write_pointer;
  logic [POINTER_WIDTH-1:0] r_write_pointer_gray;
  logic                     r_write_strobe;
  logic                     r_overflow;

  // Derived
  logic [POINTER_WIDTH-1:0] w_read_pointer_gray_sync;
  logic [POINTER_WIDTH-1:0] w_read_pointer_sync;
  logic [POINTER_WIDTH-1:0] w_write_pointer_plus_one;
  logic [POINTER_WIDTH-1:0] w_write_pointer_next;
  logic [POINTER_WIDTH-1:0] w_write_pointer_next_gray;
  logic [POINTER_WIDTH-1:0] w_fill_level;
  logic                     w_full;
  logic                     w_write_accept;
  logic                     w_write_rejected;

  asynchronous_fifo_pointer_synchronizer #(
    .WIDTH (POINTER_WIDTH)
  ) u_read_pointer_synchronizer (
    .i_clock (clock),
    .i_reset (reset),
    .i_data  (read_pointer_gray),
    .o_data  (w_read_pointer_gray_sync)
  );

  assign w_read_pointer_sync =
    POINTER_WIDTH'(gray_to_binary(pointer_word_t'(w_read_pointer_gray_sync)));

  // DATA_DEPTH is a power of two, so natural pointer-width wrap is mod DATA_DEPTH.
  assign w_write_pointer_plus_one = r_write_pointer + POINTER_WIDTH'(1);
  assign w_fill_level             = r_write_pointer - w_read_pointer_sync;
  assign w_full                   = (w_write_pointer_plus_one == w_read_pointer_sync);

  // Full is judged on registered state only; a slot freed by a read this
  // cycle is not visible yet, so a write attempted while full is still lost.
  // A write presented during reset is dropped as well.
  assign w_write_accept   = write_enable && !w_full && !reset;
  assign w_write_rejected = write_enable && w_full;

  assign w_write_pointer_next      = w_write_accept ? w_write_pointer_plus_one : r_write_pointer;
  assign w_write_pointer_next_gray =
    POINTER_WIDTH'(binary_to_gray(pointer_word_t'(w_write_pointer_next)));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_write_pointer      <= '0;
      r_write_pointer_gray <= '0;
      r_write_strobe       <= 1'b0;
      r_overflow           <= 1'b0;
    end else begin
      r_write_pointer      <= w_write_pointer_next;
      // Loaded from the next binary pointer so the published Gray value
      // comes straight from a flop and moves on the same edge as the pointer.
      r_write_pointer_gray <= w_write_pointer_next_gray;
      r_write_strobe       <= w_write_accept;
      if (w_write_rejected) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign memory_write_enable  = w_write_accept;
  assign memory_write_address = r_write_pointer;
  assign memory_write_data    = write_data;
  assign write_pointer_gray   = r_write_pointer_gray;
  assign write_strobe         = r_write_strobe;
  assign full                 = w_full;
  assign almost_full          = (w_fill_level >= POINTER_WIDTH'(ALMOST_FULL_THRESHOLD));
  assign fill_level           = w_fill_level;
  assign overflow             = r_overflow;

endmodule
